vote_session_ctrl: RTL and testbench

Sequencing controller for the five-input, three-candidate majority `voter` datapath. It opens a voting window on `start` and collects one ballot per voter channel through a request/acknowledge handshake, closing the window early once all five have voted. When the window closes it registers the `voter` result and holds it until acknowledged. It sits between the voter-channel front ends and the result consumer.

---
 rtl/voter_pkg.sv | 25 ++
 rtl/voter.sv | 31 +++
 rtl/vote_session_ctrl.sv | 135 +++++++++++++
 tb/tb_vote_session_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/voter_pkg.sv
// Shared types and constants for the majority voter and its session controller.
package voter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EVAL    = 2'd2,
    RESULT  = 2'd3
  } state_t;

  localparam logic [2:0] CAND_0     = 3'b001;
  localparam logic [2:0] CAND_1     = 3'b010;
  localparam logic [2:0] CAND_2     = 3'b100;
  localparam logic [2:0] ABSTAIN    = 3'b000;
  localparam int         NUM_VOTERS = 5;

  // Anything other than a single candidate bit counts as an abstention.
  function automatic logic [2:0] sanitize_ballot(input logic [2:0] b);
    logic [2:0] res;
    res = ABSTAIN;
    if (b == CAND_0 || b == CAND_1 || b == CAND_2) res = b;
    return res;
  endfunction

endpackage

// File: rtl/voter.sv
// Combinational five-input, three-candidate majority tally.
module voter
  import voter_pkg::*;
(
  input  logic [2:0] In_1,
  input  logic [2:0] In_2,
  input  logic [2:0] In_3,
  input  logic [2:0] In_4,
  input  logic [2:0] In_5,
  output logic [2:0] Out
);

  logic [2:0] w_c0;
  logic [2:0] w_c1;
  logic [2:0] w_c2;

  assign w_c0 = {2'b00, In_1[0]} + {2'b00, In_2[0]} + {2'b00, In_3[0]}
              + {2'b00, In_4[0]} + {2'b00, In_5[0]};
  assign w_c1 = {2'b00, In_1[1]} + {2'b00, In_2[1]} + {2'b00, In_3[1]}
              + {2'b00, In_4[1]} + {2'b00, In_5[1]};
  assign w_c2 = {2'b00, In_1[2]} + {2'b00, In_2[2]} + {2'b00, In_3[2]}
              + {2'b00, In_4[2]} + {2'b00, In_5[2]};

  // Ties fall through toward the higher candidate, so all-abstain selects CAND_2.
  always_comb begin
    Out = CAND_2;
    if (w_c0 > w_c1 && w_c0 > w_c2) Out = CAND_0;
    else if (w_c0 <= w_c1 && w_c1 > w_c2) Out = CAND_1;
  end

endmodule

// File: rtl/vote_session_ctrl.sv
// Voting-session sequencer: collects one ballot per channel within a timed window, then latches the majority winner.
module vote_session_ctrl
  import voter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       Req_1,
  input  logic       Req_2,
  input  logic       Req_3,
  input  logic       Req_4,
  input  logic       Req_5,
  input  logic [2:0] In_1,
  input  logic [2:0] In_2,
  input  logic [2:0] In_3,
  input  logic [2:0] In_4,
  input  logic [2:0] In_5,
  output logic       Ack_1,
  output logic       Ack_2,
  output logic       Ack_3,
  output logic       Ack_4,
  output logic       Ack_5,
  input  logic       Res_ack,
  output logic       Busy,
  output logic       Done,
  output logic [2:0] Out,
  output logic [4:0] Voted,
  output logic       Timeout
);

  localparam int              TW         = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMER_INIT = TW'(TIMEOUT);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [TW-1:0]           r_timer;
  logic [NUM_VOTERS-1:0]   r_voted;
  logic [NUM_VOTERS-1:0]   r_ack;
  logic                    r_timeout;
  logic [2:0]              r_out;
  logic [2:0]              r_ballot [NUM_VOTERS];

  logic [2:0]              w_in [NUM_VOTERS];
  logic [NUM_VOTERS-1:0]   w_req;
  logic [NUM_VOTERS-1:0]   w_accept;
  logic [NUM_VOTERS-1:0]   w_voted_nxt;
  logic                    w_start;
  logic                    w_all_voted;
  logic                    w_timer_zero;
  logic [2:0]              w_winner;

  assign w_in[0] = In_1;
  assign w_in[1] = In_2;
  assign w_in[2] = In_3;
  assign w_in[3] = In_4;
  assign w_in[4] = In_5;
  assign w_req   = {Req_5, Req_4, Req_3, Req_2, Req_1};

  assign w_start      = (r_state == IDLE) && start;
  assign w_accept     = (r_state == COLLECT) ? (w_req & ~r_voted) : '0;
  assign w_voted_nxt  = r_voted | w_accept;
  assign w_all_voted  = &w_voted_nxt;
  assign w_timer_zero = (r_timer == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = COLLECT;
      COLLECT: if (w_all_voted || w_timer_zero) w_state_nxt = EVAL;
      EVAL:    w_state_nxt = RESULT;
      RESULT:  if (Res_ack) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Session control: timer, voted mask, timeout flag, ack pulses and the latched winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer   <= '0;
      r_voted   <= '0;
      r_ack     <= '0;
      r_timeout <= 1'b0;
      r_out     <= ABSTAIN;
    end else begin
      r_ack <= w_accept;
      if (w_start) begin
        r_voted   <= '0;
        r_timeout <= 1'b0;
        r_timer   <= TIMER_INIT;
      end
      if (r_state == COLLECT) begin
        r_voted <= w_voted_nxt;
        if (w_timer_zero && !w_all_voted) r_timeout <= 1'b1;
        if (!w_timer_zero) r_timer <= r_timer - TW'(1);
      end
      if (r_state == EVAL) r_out <= w_winner;
    end
  end

  // Ballots are pure data; every session clears them on start before use.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_VOTERS; k++) begin
      if (w_start)          r_ballot[k] <= ABSTAIN;
      else if (w_accept[k]) r_ballot[k] <= sanitize_ballot(w_in[k]);
    end
  end

  voter u_voter (
    .In_1 (r_ballot[0]),
    .In_2 (r_ballot[1]),
    .In_3 (r_ballot[2]),
    .In_4 (r_ballot[3]),
    .In_5 (r_ballot[4]),
    .Out  (w_winner)
  );

  assign Ack_1   = r_ack[0];
  assign Ack_2   = r_ack[1];
  assign Ack_3   = r_ack[2];
  assign Ack_4   = r_ack[3];
  assign Ack_5   = r_ack[4];
  assign Busy    = (r_state != IDLE);
  assign Done    = (r_state == RESULT);
  assign Out     = r_out;
  assign Voted   = r_voted;
  assign Timeout = r_timeout;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed bench for vote_session_ctrl with a short window (TIMEOUT=7, eight COLLECT cycles).
module tb_vote_session_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       res_ack;
  logic [4:0] req;
  logic [2:0] bin [5];
  logic       Ack_1, Ack_2, Ack_3, Ack_4, Ack_5;
  logic       Busy, Done, Timeout;
  logic [2:0] Out;
  logic [4:0] Voted;
  logic [4:0] acks;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign acks = {Ack_5, Ack_4, Ack_3, Ack_2, Ack_1};

  vote_session_ctrl #(.TIMEOUT(7)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .Req_1   (req[0]),
    .Req_2   (req[1]),
    .Req_3   (req[2]),
    .Req_4   (req[3]),
    .Req_5   (req[4]),
    .In_1    (bin[0]),
    .In_2    (bin[1]),
    .In_3    (bin[2]),
    .In_4    (bin[3]),
    .In_5    (bin[4]),
    .Ack_1   (Ack_1),
    .Ack_2   (Ack_2),
    .Ack_3   (Ack_3),
    .Ack_4   (Ack_4),
    .Ack_5   (Ack_5),
    .Res_ack (res_ack),
    .Busy    (Busy),
    .Done    (Done),
    .Out     (Out),
    .Voted   (Voted),
    .Timeout (Timeout)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vote(input int k, input logic [2:0] b);
    req[k-1] = 1'b1;
    bin[k-1] = b;
    tick();
    req[k-1] = 1'b0;
  endtask

  task automatic begin_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!Done && n < 20) begin
      tick();
      n++;
    end
    check(tag, Done, 1);
  endtask

  task automatic finish_session();
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; res_ack = 1'b0; req = '0;
    for (int i = 0; i < 5; i++) bin[i] = 3'b000;
    #12;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_out", Out, 0);
    check("rst_voted", Voted, 0);
    check("rst_timeout", Timeout, 0);
    check("rst_acks", acks, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Full session, early close on the fifth ballot
    begin_session();
    check("full_busy", Busy, 1);
    check("full_noack", acks, 0);
    vote(1, 3'b001); check("full_ack1", acks, 5'b00001);
    vote(2, 3'b001); check("full_ack2", acks, 5'b00010);
    vote(3, 3'b010); check("full_ack3", acks, 5'b00100);
    vote(4, 3'b100); check("full_ack4", acks, 5'b01000);
    vote(5, 3'b001); check("full_ack5", acks, 5'b10000);
    check("full_voted", Voted, 5'b11111);
    check("full_eval_done", Done, 0);
    check("full_eval_busy", Busy, 1);
    tick();
    check("full_done", Done, 1);
    check("full_out", Out, 3'b001);
    check("full_tmo", Timeout, 0);
    check("full_ack_clear", acks, 0);
    finish_session();
    check("full_idle_busy", Busy, 0);
    check("full_idle_done", Done, 0);
    check("full_out_held", Out, 3'b001);

    // Timer close after exactly eight COLLECT cycles
    begin_session();
    vote(2, 3'b010);
    vote(3, 3'b010);
    repeat (5) tick();
    check("tmo_open_flag", Timeout, 0);
    check("tmo_open_done", Done, 0);
    tick();
    check("tmo_flag", Timeout, 1);
    check("tmo_eval_done", Done, 0);
    tick();
    check("tmo_done", Done, 1);
    check("tmo_out", Out, 3'b010);
    check("tmo_voted", Voted, 5'b00110);
    finish_session();

    // Three-way tie with one invalid ballot
    begin_session();
    vote(1, 3'b001);
    vote(2, 3'b010);
    vote(3, 3'b100);
    vote(4, 3'b111); check("tie_ack4", acks, 5'b01000);
    wait_done("tie_wait");
    check("tie_out", Out, 3'b100);
    check("tie_tmo", Timeout, 1);
    check("tie_voted", Voted, 5'b01111);
    finish_session();

    // Invalid ballot must not count toward any candidate
    begin_session();
    vote(1, 3'b001);
    vote(2, 3'b110); check("inv_ack2", acks, 5'b00010);
    wait_done("inv_wait");
    check("inv_out", Out, 3'b001);
    finish_session();

    // No ballots at all
    begin_session();
    wait_done("none_wait");
    check("none_out", Out, 3'b100);
    check("none_tmo", Timeout, 1);
    check("none_voted", Voted, 5'b00000);
    finish_session();

    // Duplicate request, then fifth ballot on the last timer cycle
    begin_session();
    vote(1, 3'b001);
    vote(1, 3'b100); check("dup_noack", acks, 5'b00000);
    vote(2, 3'b110);
    vote(3, 3'b010);
    vote(4, 3'b100);
    tick();
    tick();
    check("dup_open_done", Done, 0);
    check("dup_open_busy", Busy, 1);
    vote(5, 3'b010); check("dup_ack5", acks, 5'b10000);
    tick();
    check("dup_done", Done, 1);
    check("dup_out", Out, 3'b010);
    check("dup_tmo", Timeout, 0);
    check("dup_voted", Voted, 5'b11111);
    finish_session();

    // Asynchronous reset mid-collection
    begin_session();
    vote(1, 3'b001);
    vote(2, 3'b010);
    vote(3, 3'b100);
    check("mid_voted", Voted, 5'b00111);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_voted", Voted, 0);
    check("mid_rst_out", Out, 0);
    check("mid_rst_acks", acks, 0);
    check("mid_rst_tmo", Timeout, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", Busy, 0);
    begin_session();
    check("post_rst_busy", Busy, 1);
    check("post_rst_voted", Voted, 5'b00000);
    wait_done("post_rst_wait");

    // Res_ack and start together in RESULT; start one cycle later opens a session
    res_ack = 1'b1;
    start   = 1'b1;
    tick();
    res_ack = 1'b0;
    start   = 1'b0;
    check("hs_idle_busy", Busy, 0);
    check("hs_idle_done", Done, 0);
    begin_session();
    check("hs_new_busy", Busy, 1);
    wait_done("hs_wait");
    check("hs_out", Out, 3'b100);
    finish_session();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
